// File: rtl/mem_cmd_ctrl.sv
// mem_cmd_ctrl
// Command front-end for a single-port 16x32 memory. Read/write commands arrive
// over a valid/ready handshake and are buffered in an in-order FIFO. The FIFO
// head is turned into memory strobes at most once per cycle, and read data is
// returned on a back-pressured response port.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_write selects write (1) or read (0)
//   cmd_addr/cmd_wdata  command word address and write data
//   mem_wr_en/rd_en     memory strobes, never high together
//   mem_addr/mem_din    memory address / write data, zero when nothing issues
//   mem_dout            memory read data, valid the cycle after mem_rd_en
//   rsp_valid/ready     read response handshake, rsp_data holds while stalled
//   wr_count/rd_count   issued write/read counters, wrapping
//   idle                FIFO empty, no read in flight, no response pending
module mem_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_ready,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  idle
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    // FIFO storage (no reset needed)
    logic                  fifo_wr_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [OCC_W-1:0]      cnt_q, cnt_d;
    logic                  inflight_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [CNT_WIDTH-1:0]  wr_count_q;
    logic [CNT_WIDTH-1:0]  rd_count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic issue_wr;
    logic issue_rd;
    logic                  head_wr;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign full      = (cnt_q == OCC_W'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign cmd_ready = !full && rst_n;
    assign push      = cmd_valid && cmd_ready;

    assign head_wr   = fifo_wr_q[rptr_q];
    assign head_addr = fifo_addr_q[rptr_q];
    assign head_data = fifo_data_q[rptr_q];

    // A head read waits until the previous read has returned and the response
    // slot will be free when its data arrives; while it waits, nothing behind
    // it may issue.
    always_comb begin
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        if (!empty) begin
            if (head_wr) begin
                issue_wr = 1'b1;
            end else if (!inflight_q && (!rsp_valid_q || rsp_ready)) begin
                issue_rd = 1'b1;
            end
        end
    end

    assign pop       = issue_wr || issue_rd;
    assign mem_wr_en = issue_wr;
    assign mem_rd_en = issue_rd;
    assign mem_addr  = pop ? head_addr : '0;
    assign mem_din   = issue_wr ? head_data : '0;

    always_comb begin
        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + OCC_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr_q[wptr_q]   <= cmd_write;
            fifo_addr_q[wptr_q] <= cmd_addr;
            fifo_data_q[wptr_q] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= issue_rd;
            if (inflight_q) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= mem_dout;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (issue_wr) begin
                wr_count_q <= wr_count_q + CNT_WIDTH'(1);
            end
            if (issue_rd) begin
                rd_count_q <= rd_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;
    assign idle      = empty && !inflight_q && !rsp_valid_q;

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// tb_mem_cmd_ctrl
// Directed scenarios followed by a randomized phase. A queue-based reference
// model of the command stream predicts every output each cycle; a small
// behavioural memory answers the DUT's strobes.
module tb_mem_cmd_ctrl;

    localparam int CW    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [3:0]    cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          mem_wr_en, mem_rd_en;
    logic [3:0]    mem_addr;
    logic [31:0]   mem_din, mem_dout;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_data;
    logic [CW-1:0] wr_count, rd_count;
    logic          idle;

    int errors = 0;
    int checks = 0;

    // reference model state
    cmd_t          q[$];
    logic [31:0]   refmem [16];
    bit            inf_m, rspv_m;
    logic [31:0]   infd_m, rspd_m;
    logic [CW-1:0] wrc_m, rdc_m;
    logic [31:0]   got[$];
    bit            last_acc, last_rd, saw_not_ready;

    // behavioural memory seen by the DUT
    logic [31:0]   tbmem [16];

    mem_cmd_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_ready(rsp_ready),
        .wr_count (wr_count),
        .rd_count (rd_count),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) tbmem[mem_addr] <= mem_din;
        if (mem_rd_en) mem_dout <= tbmem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        inf_m  = 1'b0;
        rspv_m = 1'b0;
        infd_m = '0;
        rspd_m = '0;
        wrc_m  = '0;
        rdc_m  = '0;
        got.delete();
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model
    // across the following rising edge.
    task automatic tick();
        bit   ew, er, rdy;
        cmd_t h;
        @(negedge clk);
        ew  = 1'b0;
        er  = 1'b0;
        h   = '0;
        rdy = (q.size() < DEPTH);
        if (q.size() > 0) begin
            h = q[0];
            if (h.w) ew = 1'b1;
            else if (!inf_m && (!rspv_m || rsp_ready)) er = 1'b1;
        end
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, rdy});
        chk("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, ew});
        chk("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, er});
        chk("mem_addr", {28'b0, mem_addr}, (ew || er) ? {28'b0, h.a} : 32'h0);
        if (!er) chk("mem_din", mem_din, ew ? h.d : 32'h0);
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, rspv_m});
        if (rspv_m) chk("rsp_data", rsp_data, rspd_m);
        chk("idle", {31'b0, idle}, {31'b0, (q.size() == 0 && !inf_m && !rspv_m)});
        chk("wr_count", 32'(wr_count), 32'(wrc_m));
        chk("rd_count", 32'(rd_count), 32'(rdc_m));
        if (!cmd_ready) saw_not_ready = 1'b1;
        if (rspv_m && rsp_ready) got.push_back(rsp_data);
        last_rd  = er;
        last_acc = cmd_valid && rdy;
        if (inf_m) begin
            rspv_m = 1'b1;
            rspd_m = infd_m;
        end else if (rsp_ready) begin
            rspv_m = 1'b0;
        end
        inf_m = er;
        if (ew) begin
            refmem[h.a] = h.d;
            wrc_m++;
            void'(q.pop_front());
        end
        if (er) begin
            infd_m = refmem[h.a];
            rdc_m++;
            void'(q.pop_front());
        end
        if (last_acc) q.push_back('{cmd_write, cmd_addr, cmd_wdata});
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("accept_timeout", {31'b0, last_acc}, 32'h1);
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'h0);
        chk("rst_addr", {28'b0, mem_addr}, 32'h0);
        chk("rst_din", mem_din, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_rd_count", 32'(rd_count), 32'h0);
        chk("rst_idle", {31'b0, idle}, 32'h1);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset_assert();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] old7;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        mem_dout  = '0;
        saw_not_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tbmem[i]  = 32'hA500_0000 | 32'(i * 7);
            refmem[i] = 32'hA500_0000 | 32'(i * 7);
        end

        // reset then idle
        do_reset();
        idle_cycles(4);
        chk("post_reset_ready", {31'b0, cmd_ready}, 32'h1);

        // write then read back-to-back
        do_reset();
        send(1'b1, 4'd3, 32'hDEAD_BEEF);
        send(1'b0, 4'd3, 32'h0);
        idle_cycles(6);
        chk("wr_rd_data", (got.size() > 0) ? got[got.size()-1] : 32'hx, 32'hDEAD_BEEF);
        chk("wr_rd_wcnt", 32'(wr_count), 32'h1);
        chk("wr_rd_rcnt", 32'(rd_count), 32'h1);

        // fill, drain and wrap: a stalled read holds the head so writes pile up
        do_reset();
        rsp_ready = 1'b0;
        send(1'b0, 4'd8, 32'h0);
        send(1'b0, 4'd9, 32'h0);
        for (int i = 0; i < 3; i++) send(1'b1, 4'(i), 32'(i) * 32'h1111_1111);
        saw_not_ready = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = 4'd3;
        cmd_wdata = 32'h3333_3333;
        tick();
        tick();
        chk("full_block", {31'b0, last_acc}, 32'h0);
        chk("full_ready_low", {31'b0, saw_not_ready}, 32'h1);
        rsp_ready = 1'b1;
        for (int i = 3; i < 6; i++) send(1'b1, 4'(i), 32'(i) * 32'h1111_1111);
        idle_cycles(12);
        chk("fill_wcnt", 32'(wr_count), 32'h6);
        chk("fill_rcnt", 32'(rd_count), 32'h2);
        chk("fill_idle", {31'b0, idle}, 32'h1);

        // response back-pressure
        do_reset();
        rsp_ready = 1'b0;
        send(1'b0, 4'd1, 32'h0);
        send(1'b1, 4'd2, 32'hCAFE_0002);
        send(1'b0, 4'd4, 32'h0);
        idle_cycles(6);
        chk("bp_rcnt_stalled", 32'(rd_count), 32'h1);
        chk("bp_wcnt", 32'(wr_count), 32'h1);
        rsp_ready = 1'b1;
        idle_cycles(6);
        chk("bp_rcnt_done", 32'(rd_count), 32'h2);

        // ordering: read, write, read of the same address
        do_reset();
        old7 = refmem[7];
        send(1'b0, 4'd7, 32'h0);
        send(1'b1, 4'd7, 32'h1234_5678);
        send(1'b0, 4'd7, 32'h0);
        idle_cycles(8);
        chk("order_count", 32'(got.size()), 32'h2);
        chk("order_old", (got.size() > 0) ? got[0] : 32'hx, old7);
        chk("order_new", (got.size() > 1) ? got[1] : 32'hx, 32'h1234_5678);

        // reset in the cycle after a read strobe
        do_reset();
        send(1'b0, 4'd5, 32'h0);
        cmd_valid = 1'b0;
        last_rd = 1'b0;
        for (int i = 0; i < 10 && !last_rd; i++) tick();
        chk("mid_rd_seen", {31'b0, last_rd}, 32'h1);
        reset_assert();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(5);
        chk("mid_rst_rcnt", 32'(rd_count), 32'h0);
        chk("mid_rst_idle", {31'b0, idle}, 32'h1);

        // randomized traffic; enough writes to wrap the narrow counters
        do_reset();
        for (int i = 0; i < 900; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_write = ($urandom_range(0, 1) == 1);
            cmd_addr  = 4'($urandom_range(0, 15));
            cmd_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        rsp_ready = 1'b1;
        idle_cycles(20);
        chk("rand_idle", {31'b0, idle}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
